spi_master_arb: RTL and testbench

- Round-robin arbiter and transaction sequencer that shares one spi_master_io datapath between N requesters.
- Per transaction it does four things:
  - grants one requester;
  - pushes that requester's 1..8 payload bytes into the SPI TX FIFO;
  - waits for the slave-select release, signalled by the rx_access pulse;
  - returns the captured rx_data to the winner with a one-cycle done pulse.
- It sits between the register/fabric side and spi_master_io. It also drives a one-hot chip-select enable per requester.

---
 rtl/spi_master_arb.sv | 147 ++++++++++++++
 tb/tb_spi_master_arb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arb.sv
// Round-robin arbiter and byte sequencer sharing one spi_master_io among N requesters.
// Optional WAIT timeout enabled by defining SPI_MASTER_ARB_TIMEOUT_EN.
module spi_master_arb #(
    parameter int N  = 4,
    parameter int TW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [3*N-1:0]  req_len,
    input  logic [64*N-1:0] req_data,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic            err,
    output logic [63:0]     rsp_data,
    output logic [N-1:0]    cs_en,
    output logic            fifo_wr,
    output logic [7:0]      fifo_din,
    input  logic            fifo_full,
    input  logic [1:0]      spi_state,
    input  logic            rx_access,
    input  logic [63:0]     rx_data
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NU = N;

    if (N < 2 || N > 8 || TW < 2) begin : g_bad_params
        $error("spi_master_arb: N must be 2..8 and TW at least 2");
    end

    typedef enum logic [1:0] {ARB, LOAD, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] rr_ptr, win_q, win_c;
    logic          win_vld;
    logic [2:0]    len_q, cnt;
    logic [63:0]   data_q;
    logic [N-1:0]  gnt_q;
    int unsigned   idx;

`ifdef SPI_MASTER_ARB_TIMEOUT_EN
    logic [TW-1:0] tmo, tmo_nxt;
    logic          tmo_hit, err_q;

    // Leaving WAIT on the edge where the counter becomes all-ones.
    always_comb begin
        tmo_nxt = tmo + 1'b1;
        tmo_hit = &tmo_nxt;
    end
`endif

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        win_vld = 1'b0;
        win_c   = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            idx = (32'(rr_ptr) + i) % NU;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_c   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:  if (win_vld && spi_state == 2'b00) state_nxt = LOAD;
            LOAD: if (!fifo_full && cnt == len_q) state_nxt = WAIT;
            WAIT: begin
                if (rx_access) state_nxt = DONE;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
                else if (tmo_hit) state_nxt = DONE;
`endif
            end
            DONE: state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_comb begin
        gnt      = gnt_q;
        cs_en    = gnt_q;
        fifo_wr  = (state == LOAD) && !fifo_full;
        fifo_din = data_q[{cnt, 3'b000} +: 8];
        done     = (state == DONE) ? gnt_q : '0;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
        err      = (state == DONE) && err_q;
`else
        err      = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            gnt_q    <= '0;
            rr_ptr   <= '0;
            win_q    <= '0;
            cnt      <= '0;
            len_q    <= '0;
            data_q   <= '0;
            rsp_data <= '0;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
            tmo      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                ARB: if (state_nxt == LOAD) begin
                    gnt_q  <= {{(N-1){1'b0}}, 1'b1} << win_c;
                    win_q  <= win_c;
                    len_q  <= req_len[3*win_c +: 3];
                    data_q <= req_data[64*win_c +: 64];
                    cnt    <= '0;
                end
                LOAD: begin
                    if (!fifo_full) cnt <= cnt + 1'b1;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
                    if (state_nxt == WAIT) begin
                        tmo   <= '0;
                        err_q <= 1'b0;
                    end
`endif
                end
                WAIT: begin
                    if (rx_access) rsp_data <= rx_data;
`ifdef SPI_MASTER_ARB_TIMEOUT_EN
                    else begin
                        tmo <= tmo_nxt;
                        if (tmo_hit) err_q <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    gnt_q  <= '0;
                    rr_ptr <= (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed self-checking bench for spi_master_arb (N=4, default build without timeout).
module tb_spi_master_arb;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [3*N-1:0]  req_len;
    logic [64*N-1:0] req_data;
    logic [N-1:0]    gnt, done, cs_en;
    logic            err, fifo_wr, fifo_full, rx_access;
    logic [63:0]     rsp_data, rx_data;
    logic [7:0]      fifo_din;
    logic [1:0]      spi_state;

    int vectors = 0;
    int miscompares = 0;

    spi_master_arb #(.N(N), .TW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data), .cs_en(cs_en),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .spi_state(spi_state), .rx_access(rx_access), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int g;
        int n;
        int stall;
        int order [5];
        order = '{1, 2, 3, 0, 1};

        reset = 1'b1; req = '0; req_len = '0; req_data = '0;
        fifo_full = 1'b0; spi_state = 2'b00; rx_access = 1'b0; rx_data = '0;
        tick(); tick();
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_cs_en", 64'(cs_en), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_fifo_wr", 64'(fifo_wr), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_rsp", rsp_data, 64'h0);
        reset = 1'b0;

        // Single request, len=2
        req_len[2:0] = 3'd2;
        req_data[63:0] = 64'h0000_0000_0033_2211;
        req = 4'b0001;
        chk("single_pre_gnt", 64'(gnt), 64'h0);
        tick();
        chk("single_gnt", 64'(gnt), 64'h1);
        chk("single_cs_en", 64'(cs_en), 64'h1);
        chk("single_wr0", 64'(fifo_wr), 64'h1);
        chk("single_b0", 64'(fifo_din), 64'h11);
        req = 4'b0000;
        tick();
        chk("single_b1", 64'(fifo_din), 64'h22);
        tick();
        chk("single_wr2", 64'(fifo_wr), 64'h1);
        chk("single_b2", 64'(fifo_din), 64'h33);
        tick();
        chk("single_wait_wr", 64'(fifo_wr), 64'h0);
        chk("single_wait_gnt", 64'(gnt), 64'h1);
        chk("single_wait_done", 64'(done), 64'h0);
        rx_data = 64'hA5; rx_access = 1'b1;
        tick();
        rx_access = 1'b0;
        chk("single_done", 64'(done), 64'h1);
        chk("single_err", 64'(err), 64'h0);
        chk("single_rsp", rsp_data, 64'hA5);
        tick();
        chk("single_done_1cyc", 64'(done), 64'h0);
        chk("single_gnt_clr", 64'(gnt), 64'h0);

        // Round robin with all requests held; pointer now at 1
        for (int i = 0; i < N; i++) begin
            req_len[3*i +: 3] = 3'd0;
            req_data[64*i +: 64] = 64'(8'h10 + i);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = order[k];
            tick();
            chk("rr_gnt", 64'(gnt), 64'd1 << g);
            chk("rr_byte", 64'(fifo_din), 64'(8'h10 + g));
            tick();
            rx_data = 64'(16'h100 + g); rx_access = 1'b1;
            tick();
            rx_access = 1'b0;
            chk("rr_done", 64'(done), 64'd1 << g);
            chk("rr_rsp", rsp_data, 64'(16'h100 + g));
            tick();
            chk("rr_gap", 64'(gnt), 64'h0);
        end
        req = 4'b0000;

        // Back-pressure: requester 2, 8 bytes, full for 5 cycles after byte 3
        req_len[8:6] = 3'd7;
        req_data[191:128] = 64'hA7A6_A5A4_A3A2_A1A0;
        req = 4'b0100;
        tick();
        chk("bp_gnt", 64'(gnt), 64'h4);
        req = 4'b0000;
        n = 0;
        stall = 0;
        for (int j = 0; j < 20; j++) begin
            if (fifo_full) chk("bp_stall_wr", 64'(fifo_wr), 64'h0);
            if (fifo_wr) begin
                chk("bp_byte", 64'(fifo_din), 64'(8'hA0 + n));
                n++;
            end
            if (n >= 3 && stall < 5) begin
                fifo_full = 1'b1;
                stall++;
            end else begin
                fifo_full = 1'b0;
            end
            tick();
        end
        chk("bp_count", 64'(n), 64'd8);
        rx_data = 64'hDEAD_BEEF_0123_4567; rx_access = 1'b1;
        tick();
        rx_access = 1'b0;
        chk("bp_done", 64'(done), 64'h4);
        chk("bp_rsp", rsp_data, 64'hDEAD_BEEF_0123_4567);
        tick();

        // rx_access outside WAIT is ignored
        rx_data = 64'h1234; rx_access = 1'b1;
        tick();
        rx_access = 1'b0;
        chk("stray_done", 64'(done), 64'h0);
        chk("stray_rsp", rsp_data, 64'hDEAD_BEEF_0123_4567);

        // Busy master holds off the grant; pointer at 3, requester 1 wins
        spi_state = 2'b11;
        req = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("busy_no_gnt", 64'(gnt), 64'h0);
        end
        spi_state = 2'b00;
        tick();
        chk("busy_gnt", 64'(gnt), 64'h2);
        req = 4'b0000;
        tick();
        rx_data = 64'h77; rx_access = 1'b1;
        tick();
        rx_access = 1'b0;
        chk("busy_done", 64'(done), 64'h2);
        tick();

        // Reset after 2 of 5 bytes from requester 3
        req_len[11:9] = 3'd4;
        req_data[255:192] = 64'h0000_00C4_C3C2_C1C0;
        req = 4'b1000;
        tick();
        chk("mid_gnt", 64'(gnt), 64'h8);
        chk("mid_b0", 64'(fifo_din), 64'hC0);
        req = 4'b0000;
        tick();
        chk("mid_b1", 64'(fifo_din), 64'hC1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_gnt", 64'(gnt), 64'h0);
        chk("mid_rst_cs_en", 64'(cs_en), 64'h0);
        chk("mid_rst_wr", 64'(fifo_wr), 64'h0);
        chk("mid_rst_done", 64'(done), 64'h0);
        chk("mid_rst_rsp", rsp_data, 64'h0);
        tick();
        chk("mid_no_done", 64'(done), 64'h0);
        req = 4'b1001;
        tick();
        chk("mid_regrant_ptr0", 64'(gnt), 64'h1);
        chk("mid_regrant_byte", 64'(fifo_din), 64'h10);
        req = 4'b0000;
        tick();
        rx_data = 64'h99; rx_access = 1'b1;
        tick();
        rx_access = 1'b0;
        chk("mid_final_done", 64'(done), 64'h1);
        chk("mid_final_rsp", rsp_data, 64'h99);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
